rsa_seq: RTL and testbench

Parametrised RSA modular-exponentiation sequencer, successor to the fixed 4096-bit top. It latches the message, exponent and modulus operands. It drives the precompute engines over external handshake ports: R mod N and R² mod N from the Montgomery-constant engine, and n'₀ from the modular-inverse engine. It then streams limbs into the ModExp core, waits for completion and reassembles the result. Generic in operand and limb width, it adds a busy/err contract, operand latching, even-modulus rejection and per-engine timeout.

---
 rtl/rsa_seq.sv | 177 +++++++++++++++++
 tb/tb_rsa_seq.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_seq.sv
// RSA modular-exponentiation sequencer: latches operands, obtains R mod N, R^2 mod N
// and n'0 from external engines, streams limbs into the ModExp core and reassembles the result.
module rsa_seq #(
  parameter int RSA_WIDTH  = 4096,
  parameter int DATA_WIDTH = 64,
  parameter int TIMEOUT    = 2**20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  input  logic [RSA_WIDTH-1:0]  message,
  input  logic [RSA_WIDTH-1:0]  exponent,
  input  logic [RSA_WIDTH-1:0]  modulus,
  output logic [RSA_WIDTH-1:0]  cypher,
  output logic                  done,
  output logic                  busy,
  output logic                  err,
  output logic                  rt_go,
  output logic                  rt_mode,
  input  logic                  rt_done,
  input  logic [RSA_WIDTH-1:0]  rt_res,
  output logic                  inv_go,
  input  logic                  inv_valid,
  input  logic [DATA_WIDTH-1:0] inv_res,
  output logic [DATA_WIDTH-1:0] m_buf,
  output logic [DATA_WIDTH-1:0] e_buf,
  output logic [DATA_WIDTH-1:0] n_buf,
  output logic [DATA_WIDTH-1:0] r_buf,
  output logic [DATA_WIDTH-1:0] t_buf,
  output logic [DATA_WIDTH-1:0] nprime0,
  output logic                  start_input,
  output logic                  start_compute,
  output logic                  get_result,
  input  logic                  core_complete,
  input  logic [DATA_WIDTH-1:0] res_out
);

  localparam int NLIMB = RSA_WIDTH / DATA_WIDTH;
  localparam int CW    = $clog2(NLIMB) + 1;
  localparam int TW    = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    IDLE, CALC_R, CALC_T, CALC_N0, SEND, WAIT_CORE, READ, FINISH
  } state_t;

  state_t                 state, next_state;
  logic                   first;
  logic [CW-1:0]          k;
  logic [TW-1:0]          wait_cnt;
  logic                   timed_out;
  logic [RSA_WIDTH-1:0]   m_reg, e_reg, n_reg, r_reg, t_reg;

  assign timed_out = (state == CALC_R || state == CALC_T || state == CALC_N0 ||
                      state == WAIT_CORE) && (wait_cnt == TW'(TIMEOUT - 1));

  // NOTE: every output and next_state gets a default first, so no path through the case infers a latch.
  always_comb begin
    next_state    = state;
    done          = 1'b0;
    rt_go         = 1'b0;
    inv_go        = 1'b0;
    start_input   = 1'b0;
    start_compute = 1'b0;
    get_result    = 1'b0;
    m_buf         = '0;
    e_buf         = '0;
    n_buf         = '0;
    r_buf         = '0;
    t_buf         = '0;
    case (state)
      IDLE: if (go) next_state = CALC_R;
      CALC_R: begin
        // The even-modulus check happens here so that no engine request is ever issued for it.
        rt_go = first && n_reg[0];
        if (first && !n_reg[0])     next_state = FINISH;
        else if (!first && rt_done) next_state = CALC_T;
        else if (timed_out)         next_state = FINISH;
      end
      CALC_T: begin
        rt_go = first;
        if (!first && rt_done) next_state = CALC_N0;
        else if (timed_out)    next_state = FINISH;
      end
      CALC_N0: begin
        inv_go = first;
        if (!first && inv_valid) next_state = SEND;
        else if (timed_out)      next_state = FINISH;
      end
      SEND: begin
        start_input = 1'b1;
        m_buf = m_reg[int'(k)*DATA_WIDTH +: DATA_WIDTH];
        e_buf = e_reg[int'(k)*DATA_WIDTH +: DATA_WIDTH];
        n_buf = n_reg[int'(k)*DATA_WIDTH +: DATA_WIDTH];
        r_buf = r_reg[int'(k)*DATA_WIDTH +: DATA_WIDTH];
        t_buf = t_reg[int'(k)*DATA_WIDTH +: DATA_WIDTH];
        if (k == CW'(NLIMB - 1)) next_state = WAIT_CORE;
      end
      WAIT_CORE: begin
        start_compute = first;
        if (!first && core_complete) next_state = READ;
        else if (timed_out)          next_state = FINISH;
      end
      READ: begin
        get_result = 1'b1;
        if (k == CW'(NLIMB - 1)) next_state = FINISH;
      end
      FINISH: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      first <= 1'b0;
    end else begin
      state <= next_state;
      first <= (next_state != state);
    end
  end

  // NOTE: the wide operand registers are reset too, so an aborted job leaves nothing behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      k        <= '0;
      m_reg    <= '0;
      e_reg    <= '0;
      n_reg    <= '0;
      r_reg    <= '0;
      t_reg    <= '0;
      cypher   <= '0;
      nprime0  <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
      rt_mode  <= 1'b0;
    end else begin
      wait_cnt <= (next_state != state) ? '0 : wait_cnt + TW'(1);
      if ((state == SEND || state == READ) && k != CW'(NLIMB - 1)) k <= k + CW'(1);
      else                                                         k <= '0;
      case (state)
        IDLE: if (go) begin
          m_reg   <= message;
          e_reg   <= exponent;
          n_reg   <= modulus;
          err     <= 1'b0;
          busy    <= 1'b1;
          rt_mode <= 1'b0;
        end
        CALC_R: begin
          if (next_state == FINISH) err <= 1'b1;
          else if (next_state == CALC_T) begin
            r_reg   <= rt_res;
            rt_mode <= 1'b1;
          end
        end
        CALC_T: begin
          if (next_state == FINISH)       err   <= 1'b1;
          else if (next_state == CALC_N0) t_reg <= rt_res;
        end
        CALC_N0: begin
          if (next_state == FINISH)    err     <= 1'b1;
          else if (next_state == SEND) nprime0 <= inv_res;
        end
        WAIT_CORE: if (next_state == FINISH) err <= 1'b1;
        READ:      cypher[int'(k)*DATA_WIDTH +: DATA_WIDTH] <= res_out;
        FINISH:    busy <= 1'b0;
        default:   ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_seq.sv
// Self-checking bench for rsa_seq: behavioural engines and core, scoreboard of expected results.
module tb_rsa_seq;

  localparam int RW = 256;
  localparam int DW = 64;
  localparam int TO = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          go;
  logic [RW-1:0] message, exponent, modulus, cypher, rt_res;
  logic          done, busy, err, rt_go, rt_mode, rt_done, inv_go, inv_valid;
  logic [DW-1:0] inv_res, m_buf, e_buf, n_buf, r_buf, t_buf, nprime0, res_out;
  logic          start_input, start_compute, get_result, core_complete;

  rsa_seq #(.RSA_WIDTH(RW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .go(go),
    .message(message), .exponent(exponent), .modulus(modulus),
    .cypher(cypher), .done(done), .busy(busy), .err(err),
    .rt_go(rt_go), .rt_mode(rt_mode), .rt_done(rt_done), .rt_res(rt_res),
    .inv_go(inv_go), .inv_valid(inv_valid), .inv_res(inv_res),
    .m_buf(m_buf), .e_buf(e_buf), .n_buf(n_buf), .r_buf(r_buf), .t_buf(t_buf),
    .nprime0(nprime0), .start_input(start_input), .start_compute(start_compute),
    .get_result(get_result), .core_complete(core_complete), .res_out(res_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] cy;
    logic          er;
  } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // Reference arithmetic for small operands.
  function automatic logic [63:0] modexp(input logic [63:0] b, input logic [63:0] e,
                                         input logic [63:0] n);
    logic [127:0] acc, base;
    acc  = 128'd1;
    base = {64'd0, b} % {64'd0, n};
    for (int i = 0; i < 64; i++) begin
      if (e[i]) acc = (acc * base) % {64'd0, n};
      base = (base * base) % {64'd0, n};
    end
    return acc[63:0];
  endfunction

  logic [RW-1:0] r_val, t_val;
  logic [DW-1:0] np_val;

  task automatic compute_consts(input logic [63:0] n);
    logic [63:0] r, x;
    r = 64'd1;
    for (int i = 0; i < RW; i++) r = (r * 64'd2) % n;
    r_val = {192'd0, r};
    t_val = {192'd0, (r * r) % n};
    x = n;
    for (int i = 0; i < 5; i++) x = x * (64'd2 - n * x);
    np_val = -x;
  endtask

  // Montgomery-constant engine model: answers 3 cycles after a request, or holds rt_done high.
  logic rt_hold, rt_pulse, rt_m;
  int   rt_cnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rt_cnt <= 0; rt_pulse <= 1'b0; rt_m <= 1'b0;
    end else begin
      rt_pulse <= 1'b0;
      if (rt_go) begin
        rt_cnt <= 3; rt_m <= rt_mode;
      end else if (rt_cnt != 0) begin
        rt_cnt <= rt_cnt - 1;
        if (rt_cnt == 1) rt_pulse <= 1'b1;
      end
    end
  end
  assign rt_done = rt_hold | rt_pulse;
  assign rt_res  = (rt_hold ? rt_mode : rt_m) ? t_val : r_val;

  // Modular-inverse engine model; inv_en=0 makes it silent.
  logic inv_en, inv_pulse;
  int   inv_cnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      inv_cnt <= 0; inv_pulse <= 1'b0;
    end else begin
      inv_pulse <= 1'b0;
      if (inv_go) inv_cnt <= 3;
      else if (inv_cnt != 0) begin
        inv_cnt <= inv_cnt - 1;
        if (inv_cnt == 1) inv_pulse <= 1'b1;
      end
    end
  end
  assign inv_valid = inv_pulse & inv_en;
  assign inv_res   = np_val;

  // ModExp core model: gathers limbs, computes from limb 0, returns the result limb by limb.
  logic [RW-1:0] cap_m, cap_e, cap_n, cap_r, cap_t;
  logic [DW-1:0] cap_np, core_res;
  logic          cc_pulse;
  int            beat, cc_cnt, rk;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat <= 0; cc_cnt <= 0; cc_pulse <= 1'b0; rk <= 0; core_res <= '0;
      cap_m <= '0; cap_e <= '0; cap_n <= '0; cap_r <= '0; cap_t <= '0; cap_np <= '0;
    end else begin
      cc_pulse <= 1'b0;
      if (start_input) begin
        cap_m[beat*DW +: DW] <= m_buf;
        cap_e[beat*DW +: DW] <= e_buf;
        cap_n[beat*DW +: DW] <= n_buf;
        cap_r[beat*DW +: DW] <= r_buf;
        cap_t[beat*DW +: DW] <= t_buf;
        cap_np <= nprime0;
        beat   <= beat + 1;
      end
      if (start_compute) begin
        beat     <= 0;
        rk       <= 0;
        core_res <= modexp(cap_m[63:0], cap_e[63:0], cap_n[63:0]);
        cc_cnt   <= 3;
      end else if (cc_cnt != 0) begin
        cc_cnt <= cc_cnt - 1;
        if (cc_cnt == 1) cc_pulse <= 1'b1;
      end
      if (get_result) rk <= rk + 1;
    end
  end
  assign core_complete = cc_pulse;
  assign res_out       = (rk == 0) ? core_res : '0;

  // Free-running event counters; tests compare differences of snapshots.
  int cnt_si = 0, cnt_rt = 0, cnt_inv = 0, cnt_done = 0;
  always @(negedge clk) begin
    if (start_input) cnt_si++;
    if (rt_go)       cnt_rt++;
    if (inv_go)      cnt_inv++;
    if (done)        cnt_done++;
  end

  // Returns at the negedge of the first post-acceptance cycle.
  task automatic do_go(input logic [RW-1:0] m, input logic [RW-1:0] e, input logic [RW-1:0] n);
    @(negedge clk);
    message = m; exponent = e; modulus = n; go = 1'b1;
    @(posedge clk);
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      if (done === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic check_result(input string name);
    exp_t x;
    x = exp_q.pop_front();
    total++;
    if (cypher !== x.cy) begin
      bad++; $display("FAIL %s cypher: got %0h want %0h", name, cypher, x.cy);
    end
    total++;
    if (err !== x.er) begin
      bad++; $display("FAIL %s err: got %0b want %0b", name, err, x.er);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    total++;
    if ({done, busy, err, rt_go, rt_mode, inv_go, start_input, start_compute, get_result} !== 9'd0) begin
      bad++;
      $display("FAIL %s ctrl: got %b want 000000000", name,
               {done, busy, err, rt_go, rt_mode, inv_go, start_input, start_compute, get_result});
    end
    total++;
    if ({cypher, m_buf, e_buf, n_buf, r_buf, t_buf, nprime0} !== '0) begin
      bad++; $display("FAIL %s data: got cypher=%0h nprime0=%0h want 0", name, cypher, nprime0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; go = 1'b0; message = '0; exponent = '0; modulus = '0;
    rt_hold = 1'b0; inv_en = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int si0, d0;
    bit seen;
    si0 = cnt_si; d0 = cnt_done;
    exp_q.push_back('{cy: 256'd26, er: 1'b0});
    do_go(256'd5, 256'd3, 256'd33);
    total++;
    if ({busy, rt_go, rt_mode} !== 3'b110) begin
      bad++; $display("FAIL basic first cycle busy/rt_go/rt_mode: got %b want 110", {busy, rt_go, rt_mode});
    end
    wait_done(300, seen);
    total++;
    if (!seen) begin bad++; $display("FAIL basic done timeout: got none want done"); end
    check_result("basic");
    @(negedge clk);
    total++;
    if ({done, busy} !== 2'b00) begin bad++; $display("FAIL basic after done: got %b want 00", {done, busy}); end
    total++;
    if (cnt_si - si0 != 4) begin bad++; $display("FAIL basic beats: got %0d want 4", cnt_si - si0); end
    total++;
    if (cnt_done - d0 != 1) begin bad++; $display("FAIL basic done count: got %0d want 1", cnt_done - d0); end
    total++;
    if ({cap_m, cap_e, cap_n} !== {256'd5, 256'd3, 256'd33}) begin
      bad++; $display("FAIL basic operands: got m=%0h e=%0h n=%0h want 5 3 21", cap_m, cap_e, cap_n);
    end
    total++;
    if ({cap_r, cap_t, cap_np} !== {r_val, t_val, np_val}) begin
      bad++; $display("FAIL basic constants: got r=%0h t=%0h np=%0h want r=%0h t=%0h np=%0h",
                      cap_r, cap_t, cap_np, r_val, t_val, np_val);
    end
  endtask

  task automatic test_even();
    int rt0, inv0;
    rt0 = cnt_rt; inv0 = cnt_inv;
    exp_q.push_back('{cy: 256'd26, er: 1'b1});
    do_go(256'd9, 256'd3, 256'd32);
    total++;
    if ({done, busy} !== 2'b01) begin bad++; $display("FAIL even E+1: got done,busy=%b want 01", {done, busy}); end
    @(negedge clk);
    total++;
    if ({done, busy, err} !== 3'b111) begin
      bad++; $display("FAIL even E+2: got done,busy,err=%b want 111", {done, busy, err});
    end
    check_result("even");
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL even busy drop: got %b want 0", busy); end
    total++;
    if (cnt_rt != rt0 || cnt_inv != inv0) begin
      bad++; $display("FAIL even requests: got rt=%0d inv=%0d want 0 0", cnt_rt - rt0, cnt_inv - inv0);
    end
  endtask

  task automatic test_timeout();
    int si0, n;
    inv_en = 1'b0;
    si0 = cnt_si;
    exp_q.push_back('{cy: 256'd26, er: 1'b1});
    do_go(256'd5, 256'd3, 256'd33);
    n = 0;
    while (inv_go !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    total++;
    if (inv_go !== 1'b1) begin bad++; $display("FAIL timeout inv_go: got none want pulse"); end
    n = 0;
    while (done !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    total++;
    if (n != TO) begin bad++; $display("FAIL timeout latency: got %0d want %0d", n, TO); end
    check_result("timeout");
    total++;
    if (cnt_si != si0) begin bad++; $display("FAIL timeout start_input: got %0d beats want 0", cnt_si - si0); end
    inv_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [RW-1:0] m0;
    int n, d0;
    bit seen;
    m0 = {64'hA, 64'hB, 64'hC, 64'd7};
    exp_q.push_back('{cy: {192'd0, modexp(64'd7, 64'd5, 64'd33)}, er: 1'b0});
    do_go(m0, 256'd5, 256'd33);
    n = 0;
    while (start_input !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    go = 1'b1; message = ~m0; exponent = 256'd9; modulus = 256'd35;
    @(negedge clk);
    go = 1'b0;
    d0 = cnt_done;
    wait_done(300, seen);
    total++;
    if (!seen) begin bad++; $display("FAIL b2b done timeout: got none want done"); end
    check_result("b2b");
    total++;
    if ({cap_m, cap_e, cap_n} !== {m0, 256'd5, 256'd33}) begin
      bad++; $display("FAIL b2b latched operands: got m=%0h e=%0h n=%0h want m=%0h e=5 n=21",
                      cap_m, cap_e, cap_n, m0);
    end
    repeat (20) @(negedge clk);
    total++;
    if (cnt_done - d0 != 1 || busy !== 1'b0) begin
      bad++; $display("FAIL b2b extra job: got dones=%0d busy=%b want 1 0", cnt_done - d0, busy);
    end
  endtask

  task automatic test_rt_hold();
    logic [7:0] go_seq, mode_seq, inv_seq;
    bit seen;
    go_seq = '0; mode_seq = '0; inv_seq = '0;
    rt_hold = 1'b1;
    exp_q.push_back('{cy: 256'd26, er: 1'b0});
    do_go(256'd5, 256'd3, 256'd33);
    for (int j = 0; j < 8; j++) begin
      go_seq[j]   = rt_go;
      inv_seq[j]  = inv_go;
      mode_seq[j] = rt_go & rt_mode;
      @(negedge clk);
    end
    rt_hold = 1'b0;
    total++;
    if ({go_seq, mode_seq, inv_seq} !== {8'b0000_0101, 8'b0000_0100, 8'b0001_0000}) begin
      bad++; $display("FAIL rt_hold sequence: got go=%b mode=%b inv=%b want 00000101 00000100 00010000",
                      go_seq, mode_seq, inv_seq);
    end
    wait_done(300, seen);
    total++;
    if (!seen) begin bad++; $display("FAIL rt_hold done timeout: got none want done"); end
    check_result("rt_hold");
    total++;
    if ({cap_r, cap_t} !== {r_val, t_val}) begin
      bad++; $display("FAIL rt_hold constants: got r=%0h t=%0h want r=%0h t=%0h", cap_r, cap_t, r_val, t_val);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    int n, d0;
    bit seen;
    do_go(256'd5, 256'd3, 256'd33);
    n = 0;
    while (get_result !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    total++;
    if (get_result !== 1'b1) begin bad++; $display("FAIL rstread get_result: got none want READ"); end
    d0 = cnt_done;
    reset = 1'b0;
    #1;
    check_idle_outputs("rstread");
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if (cnt_done != d0) begin bad++; $display("FAIL rstread done after abort: got %0d want 0", cnt_done - d0); end
    exp_q.push_back('{cy: 256'd26, er: 1'b0});
    do_go(256'd5, 256'd3, 256'd33);
    wait_done(300, seen);
    total++;
    if (!seen) begin bad++; $display("FAIL rstread fresh job: got none want done"); end
    check_result("rstread");
  endtask

  initial begin
    compute_consts(64'd33);
    test_reset();
    test_basic();
    test_even();
    test_timeout();
    test_back_to_back();
    test_rt_hold();
    test_reset_mid_read();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard leftover: got %0d want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
